// File: rtl/minisrc_control_sequencer.sv
// -----------------------------------------------------------------------------
// minisrc_control_sequencer
//
// Hard-wired control unit for the Mini SRC processor. A step counter walks
// through fetch (T0-T2) and the per-opcode execute steps (T3-T7). All datapath
// strobes are a combinational decode of the registered step and IR[31:27],
// gated by Run so that reset and HALT present an all-zero strobe set.
//
// Optional feature macro: SEQ_MEM_WAIT_EN
//   defined   : Read/Write steps hold until mem_ready=1 is sampled.
//   undefined : memory is single-cycle, mem_ready is ignored.
//
// Ports
//   Clock      in   system clock, rising edge
//   clear      in   asynchronous active-low reset
//   IR[31:0]   in   instruction register, opcode in IR[31:27]
//   CON        in   branch condition flag
//   Stop       in   halt request, sampled on the final step of an instruction
//   mem_ready  in   memory access complete
//   PCout PCin IncPC MARin MDRin MDRout IRin Yin Zin Zlowout   out  datapath strobes
//   Gra Grb Grc Rin Rout BAout Cout CONin                      out  register/bus strobes
//   Read Write out  memory strobes
//   alu_op[1:0] out ALU operation: 0 ADD, 1 SUB, 2 AND, 3 OR
//   Run        out  high while executing
//   illegal    out  sticky unknown-opcode flag
//   step[3:0]  out  current step: 0-7 = T0-T7, 8 = HALT
// -----------------------------------------------------------------------------
module minisrc_control_sequencer (
   input  logic        Clock,
   input  logic        clear,
   input  logic [31:0] IR,
   input  logic        CON,
   input  logic        Stop,
   input  logic        mem_ready,
   output logic        PCout,
   output logic        PCin,
   output logic        IncPC,
   output logic        MARin,
   output logic        MDRin,
   output logic        MDRout,
   output logic        IRin,
   output logic        Yin,
   output logic        Zin,
   output logic        Zlowout,
   output logic        Gra,
   output logic        Grb,
   output logic        Grc,
   output logic        Rin,
   output logic        Rout,
   output logic        BAout,
   output logic        Cout,
   output logic        CONin,
   output logic        Read,
   output logic        Write,
   output logic [1:0]  alu_op,
   output logic        Run,
   output logic        illegal,
   output logic [3:0]  step
);

   localparam logic [4:0] OP_LD   = 5'b00000;
   localparam logic [4:0] OP_ST   = 5'b00010;
   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b00101;
   localparam logic [4:0] OP_OR   = 5'b00110;
   localparam logic [4:0] OP_ADDI = 5'b01100;
   localparam logic [4:0] OP_ANDI = 5'b01101;
   localparam logic [4:0] OP_ORI  = 5'b01110;
   localparam logic [4:0] OP_BR   = 5'b10010;
   localparam logic [4:0] OP_NOP  = 5'b11010;
   localparam logic [4:0] OP_HALT = 5'b11011;

   localparam int NUM_LEGAL = 12;
   localparam logic [5*NUM_LEGAL-1:0] LEGAL_OPS = {
      OP_LD, OP_ST, OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_ADDI, OP_ANDI, OP_ORI, OP_BR, OP_NOP, OP_HALT
   };

   typedef enum logic [3:0] {
      S_T0   = 4'd0,
      S_T1   = 4'd1,
      S_T2   = 4'd2,
      S_T3   = 4'd3,
      S_T4   = 4'd4,
      S_T5   = 4'd5,
      S_T6   = 4'd6,
      S_T7   = 4'd7,
      S_HALT = 4'd8
   } step_t;

   step_t step_reg, step_next;
   logic  run_reg, run_next;
   logic  illegal_reg, illegal_next;

   logic [4:0]           opcode;
   logic [NUM_LEGAL-1:0] legal_hit;
   logic                 is_legal, is_alu, is_imm, is_ld, is_st, is_br, is_nop, is_halt;
   logic                 mem_step, mem_ok, hold, last_step;
   logic [1:0]           op_alu;
   logic                 unused_ir;

   assign opcode    = IR[31:27];
   assign unused_ir = ^IR[26:0];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_LEGAL; gi++) begin : g_legal
         assign legal_hit[gi] = (opcode == LEGAL_OPS[gi*5 +: 5]);
      end
   endgenerate

   assign is_legal = |legal_hit;
   assign is_alu   = (opcode == OP_ADD)  || (opcode == OP_SUB)  || (opcode == OP_AND) || (opcode == OP_OR);
   assign is_imm   = (opcode == OP_ADDI) || (opcode == OP_ANDI) || (opcode == OP_ORI);
   assign is_ld    = (opcode == OP_LD);
   assign is_st    = (opcode == OP_ST);
   assign is_br    = (opcode == OP_BR);
   assign is_halt  = (opcode == OP_HALT);
   // Unknown opcodes behave exactly like nop.
   assign is_nop   = (opcode == OP_NOP) || !is_legal;

   always_comb begin
      op_alu = 2'd0;
      case (opcode)
         OP_SUB:          op_alu = 2'd1;
         OP_AND, OP_ANDI: op_alu = 2'd2;
         OP_OR,  OP_ORI:  op_alu = 2'd3;
         default:         op_alu = 2'd0;
      endcase
   end

   assign mem_step = (step_reg == S_T1) ||
                     ((step_reg == S_T6) && is_ld) ||
                     ((step_reg == S_T7) && is_st);

`ifdef SEQ_MEM_WAIT_EN
   assign mem_ok = mem_ready;
`else
   logic unused_mem_ready;
   assign unused_mem_ready = mem_ready;
   assign mem_ok = 1'b1;
`endif

   assign hold = mem_step && !mem_ok;

   // Final step of each instruction class: the only place Stop is looked at.
   assign last_step = ((step_reg == S_T3) && is_nop) ||
                      ((step_reg == S_T5) && (is_alu || is_imm)) ||
                      ((step_reg == S_T6) && is_br) ||
                      ((step_reg == S_T7) && (is_ld || is_st));

   always_comb begin
      step_next    = step_reg;
      run_next     = run_reg;
      illegal_next = illegal_reg;
      if (!run_reg) begin
         // Leaving reset: start running with T0 shown in the following cycle.
         // HALT is only left through clear.
         if (step_reg != S_HALT) begin
            run_next = 1'b1;
         end
      end else if (!hold) begin
         if ((step_reg == S_T3) && is_halt) begin
            step_next = S_HALT;
            run_next  = 1'b0;
         end else if (last_step) begin
            if (Stop) begin
               step_next = S_HALT;
               run_next  = 1'b0;
            end else begin
               step_next = S_T0;
            end
         end else begin
            step_next = step_t'(step_reg + 4'd1);
         end
         if ((step_reg == S_T3) && !is_legal) begin
            illegal_next = 1'b1;
         end
      end
   end

   always_ff @(posedge Clock or negedge clear) begin
      if (!clear) begin
         step_reg    <= S_T0;
         run_reg     <= 1'b0;
         illegal_reg <= 1'b0;
      end else begin
         step_reg    <= step_next;
         run_reg     <= run_next;
         illegal_reg <= illegal_next;
      end
   end

   assign Run     = run_reg;
   assign step    = step_reg;
   // Flag is visible already during the offending T3 and stays set afterwards.
   assign illegal = illegal_reg || (run_reg && (step_reg == S_T3) && !is_legal);

   // Strobe decode; Run gating forces everything low in reset and HALT.
   always_comb begin
      PCout = 1'b0; PCin = 1'b0; IncPC = 1'b0; MARin = 1'b0; MDRin = 1'b0;
      MDRout = 1'b0; IRin = 1'b0; Yin = 1'b0; Zin = 1'b0; Zlowout = 1'b0;
      Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0;
      BAout = 1'b0; Cout = 1'b0; CONin = 1'b0; Read = 1'b0; Write = 1'b0;
      alu_op = 2'd0;
      if (run_reg) begin
         case (step_reg)
            S_T0: begin
               PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
            end
            S_T1: begin
               Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
            end
            S_T2: begin
               MDRout = 1'b1; IRin = 1'b1;
            end
            S_T3: begin
               if (is_alu || is_imm) begin
                  Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
               end else if (is_ld || is_st) begin
                  Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
               end else if (is_br) begin
                  Gra = 1'b1; Rout = 1'b1; CONin = 1'b1;
               end
            end
            S_T4: begin
               if (is_alu) begin
                  Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = op_alu;
               end else if (is_imm) begin
                  Cout = 1'b1; Zin = 1'b1; alu_op = op_alu;
               end else if (is_ld || is_st) begin
                  Cout = 1'b1; Zin = 1'b1;
               end else if (is_br) begin
                  PCout = 1'b1; Yin = 1'b1;
               end
            end
            S_T5: begin
               if (is_alu || is_imm) begin
                  Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
               end else if (is_ld || is_st) begin
                  Zlowout = 1'b1; MARin = 1'b1;
               end else if (is_br) begin
                  Cout = 1'b1; Zin = 1'b1;
               end
            end
            S_T6: begin
               if (is_ld) begin
                  Read = 1'b1; MDRin = 1'b1;
               end else if (is_st) begin
                  Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
               end else if (is_br) begin
                  Zlowout = 1'b1; PCin = CON;
               end
            end
            S_T7: begin
               if (is_ld) begin
                  MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
               end else if (is_st) begin
                  Write = 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_minisrc_control_sequencer.sv
// -----------------------------------------------------------------------------
// tb_minisrc_control_sequencer
//
// Self-checking bench. A reference model expands each instruction into the
// list of strobe sets it should produce (fetch + per-instruction body, with
// memory steps repeated for wait states), drives randomized operands, wait
// counts and don't-care inputs, and compares every cycle against the DUT.
// -----------------------------------------------------------------------------
module tb_minisrc_control_sequencer;

   logic        Clock = 1'b0;
   logic        clear = 1'b1;
   logic [31:0] IR = '0;
   logic        CON = 1'b0;
   logic        Stop = 1'b0;
   logic        mem_ready = 1'b0;
   logic PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin, Zlowout;
   logic Gra, Grb, Grc, Rin, Rout, BAout, Cout, CONin, Read, Write;
   logic [1:0] alu_op;
   logic       Run, illegal;
   logic [3:0] step;

   minisrc_control_sequencer dut (
      .Clock(Clock), .clear(clear), .IR(IR), .CON(CON), .Stop(Stop), .mem_ready(mem_ready),
      .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
      .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout),
      .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
      .Cout(Cout), .CONin(CONin), .Read(Read), .Write(Write), .alu_op(alu_op),
      .Run(Run), .illegal(illegal), .step(step)
   );

   always #5 Clock = ~Clock;

`ifdef SEQ_MEM_WAIT_EN
   localparam bit WAIT_EN = 1'b1;
`else
   localparam bit WAIT_EN = 1'b0;
`endif

   localparam logic [4:0] OP_LD = 5'b00000, OP_ST = 5'b00010, OP_ADD = 5'b00011;
   localparam logic [4:0] OP_SUB = 5'b00100, OP_AND = 5'b00101, OP_OR = 5'b00110;
   localparam logic [4:0] OP_ADDI = 5'b01100, OP_ANDI = 5'b01101, OP_ORI = 5'b01110;
   localparam logic [4:0] OP_BR = 5'b10010, OP_NOP = 5'b11010, OP_HALT = 5'b11011;

   // Strobe word layout: [21:2] strobes, [1:0] alu_op
   localparam logic [21:0] M_PCOUT = 22'b1 << 21, M_PCIN  = 22'b1 << 20, M_INCPC = 22'b1 << 19;
   localparam logic [21:0] M_MARIN = 22'b1 << 18, M_MDRIN = 22'b1 << 17, M_MDROUT = 22'b1 << 16;
   localparam logic [21:0] M_IRIN  = 22'b1 << 15, M_YIN   = 22'b1 << 14, M_ZIN   = 22'b1 << 13;
   localparam logic [21:0] M_ZLOW  = 22'b1 << 12, M_GRA   = 22'b1 << 11, M_GRB   = 22'b1 << 10;
   localparam logic [21:0] M_GRC   = 22'b1 << 9,  M_RIN   = 22'b1 << 8,  M_ROUT  = 22'b1 << 7;
   localparam logic [21:0] M_BAOUT = 22'b1 << 6,  M_COUT  = 22'b1 << 5,  M_CONIN = 22'b1 << 4;
   localparam logic [21:0] M_READ  = 22'b1 << 3,  M_WRITE = 22'b1 << 2;
   localparam logic [21:0] W_T0 = M_PCOUT | M_MARIN | M_INCPC | M_ZIN;

   typedef struct packed {
      logic        run;
      logic [3:0]  stp;
      logic [21:0] word;
   } snap_t;

   snap_t exp_q[$], obs_q[$], cur_exp[$];
   bit    cur_rdy[$];
   int    checks = 0;
   int    errors = 0;
   bit    exp_illegal = 1'b0;

   function automatic logic [21:0] dut_word();
      return {PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin, Zlowout,
              Gra, Grb, Grc, Rin, Rout, BAout, Cout, CONin, Read, Write, alu_op};
   endfunction

   function automatic bit is_legal_op(input logic [4:0] op);
      return op inside {OP_LD, OP_ST, OP_ADD, OP_SUB, OP_AND, OP_OR,
                        OP_ADDI, OP_ANDI, OP_ORI, OP_BR, OP_NOP, OP_HALT};
   endfunction

   // Reference model: list of strobe sets for one instruction, one entry per cycle.
   task automatic model_instr(input logic [4:0] op, input bit con, input int w);
      logic [21:0] body[$];
      logic [21:0] aluw;
      int reps;
      cur_exp.delete();
      cur_rdy.delete();
      aluw = '0;
      if (op == OP_SUB) aluw = 22'd1;
      if (op == OP_AND || op == OP_ANDI) aluw = 22'd2;
      if (op == OP_OR  || op == OP_ORI)  aluw = 22'd3;
      body.push_back(W_T0);
      body.push_back(M_ZLOW | M_PCIN | M_READ | M_MDRIN);
      body.push_back(M_MDROUT | M_IRIN);
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR: begin
            body.push_back(M_GRB | M_ROUT | M_YIN);
            body.push_back(M_GRC | M_ROUT | M_ZIN | aluw);
            body.push_back(M_ZLOW | M_GRA | M_RIN);
         end
         OP_ADDI, OP_ANDI, OP_ORI: begin
            body.push_back(M_GRB | M_ROUT | M_YIN);
            body.push_back(M_COUT | M_ZIN | aluw);
            body.push_back(M_ZLOW | M_GRA | M_RIN);
         end
         OP_LD, OP_ST: begin
            body.push_back(M_GRB | M_BAOUT | M_YIN);
            body.push_back(M_COUT | M_ZIN);
            body.push_back(M_ZLOW | M_MARIN);
            if (op == OP_LD) begin
               body.push_back(M_READ | M_MDRIN);
               body.push_back(M_MDROUT | M_GRA | M_RIN);
            end else begin
               body.push_back(M_GRA | M_ROUT | M_MDRIN);
               body.push_back(M_WRITE);
            end
         end
         OP_BR: begin
            body.push_back(M_GRA | M_ROUT | M_CONIN);
            body.push_back(M_PCOUT | M_YIN);
            body.push_back(M_COUT | M_ZIN);
            body.push_back(M_ZLOW | (con ? M_PCIN : 22'd0));
         end
         default: body.push_back(22'd0);
      endcase
      foreach (body[k]) begin
         bit is_mem;
         is_mem = |(body[k] & (M_READ | M_WRITE));
         reps = (is_mem && WAIT_EN) ? w + 1 : 1;
         for (int r = 0; r < reps; r++) begin
            cur_exp.push_back({1'b1, 4'(k), body[k]});
            if (is_mem) cur_rdy.push_back(WAIT_EN ? (r == reps - 1) : 1'b0);
            else        cur_rdy.push_back(1'($urandom_range(0, 1)));
         end
      end
   endtask

   // Drives one instruction from its T0 cycle and records the DUT each cycle.
   task automatic run_instr(input logic [4:0] op, input bit con, input int w,
                            input bit stop, input int stop_from);
      model_instr(op, con, w);
      foreach (cur_exp[i]) begin
         if (cur_exp[i].stp == 4'd3) IR = {op, 27'($urandom)};
         CON = con;
         mem_ready = cur_rdy[i];
         Stop = stop && (int'(cur_exp[i].stp) >= stop_from);
         #1;
         exp_q.push_back(cur_exp[i]);
         obs_q.push_back({Run, step, dut_word()});
         @(posedge Clock);
         #1;
      end
      Stop = 1'b0;
      mem_ready = 1'b0;
      if (!is_legal_op(op)) exp_illegal = 1'b1;
   endtask

   task automatic test_reset();
      #1 clear = 1'b0;
      repeat (3) begin
         mem_ready = 1'($urandom); Stop = 1'($urandom); IR = $urandom;
         @(posedge Clock);
         #1;
      end
      IR = '0; Stop = 1'b0;
      checks++;
      if ({Run, step, dut_word(), illegal} !== 28'd0) begin
         errors++;
         $display("FAIL reset_state: run=%b step=%0d word=%h illegal=%b, expected all zero",
                  Run, step, dut_word(), illegal);
      end
      clear = 1'b1;
      @(posedge Clock);
      #1;
      checks++;
      if ({Run, step, dut_word()} !== {1'b1, 4'd0, W_T0}) begin
         errors++;
         $display("FAIL reset_release: run=%b step=%0d word=%h, expected run=1 step=0 word=%h",
                  Run, step, dut_word(), W_T0);
      end
   endtask

   task automatic test_alu();
      logic [4:0] pool [7];
      logic [4:0] ops[$];
      pool = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_ANDI, OP_ORI};
      ops = {OP_ADD, OP_SUB, OP_AND, OP_ORI};
      repeat (6) ops.push_back(pool[$urandom_range(0, 6)]);
      exp_q.delete(); obs_q.delete();
      foreach (ops[n]) run_instr(ops[n], 1'($urandom_range(0, 1)), $urandom_range(0, 2), 1'b0, 0);
      for (int i = 0; i < obs_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL alu cycle %0d: got run=%b step=%0d word=%h, expected run=%b step=%0d word=%h",
                     i, obs_q[i].run, obs_q[i].stp, obs_q[i].word, exp_q[i].run, exp_q[i].stp, exp_q[i].word);
         end
      end
   endtask

   task automatic test_mem_wait();
      exp_q.delete(); obs_q.delete();
      run_instr(OP_LD, 1'b0, 3, 1'b0, 0);
      run_instr(OP_ST, 1'b1, 2, 1'b0, 0);
      run_instr(OP_LD, 1'b1, 0, 1'b0, 0);
      run_instr(OP_ST, 1'b0, 0, 1'b0, 0);
      run_instr(OP_LD, 1'b0, $urandom_range(1, 4), 1'b0, 0);
      for (int i = 0; i < obs_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL mem_wait cycle %0d: got run=%b step=%0d word=%h, expected run=%b step=%0d word=%h",
                     i, obs_q[i].run, obs_q[i].stp, obs_q[i].word, exp_q[i].run, exp_q[i].stp, exp_q[i].word);
         end
      end
   endtask

   task automatic test_branch();
      exp_q.delete(); obs_q.delete();
      run_instr(OP_BR, 1'b0, 0, 1'b0, 0);
      run_instr(OP_BR, 1'b1, 1, 1'b0, 0);
      run_instr(OP_NOP, 1'b1, 0, 1'b0, 0);
      repeat (3) run_instr(OP_BR, 1'($urandom_range(0, 1)), $urandom_range(0, 2), 1'b0, 0);
      for (int i = 0; i < obs_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL branch cycle %0d: got run=%b step=%0d word=%h, expected run=%b step=%0d word=%h",
                     i, obs_q[i].run, obs_q[i].stp, obs_q[i].word, exp_q[i].run, exp_q[i].stp, exp_q[i].word);
         end
      end
   endtask

   task automatic test_illegal();
      checks++;
      if (illegal !== 1'b0) begin
         errors++;
         $display("FAIL illegal_initial: got %b, expected 0", illegal);
      end
      exp_q.delete(); obs_q.delete();
      run_instr(5'b11111, 1'b0, 0, 1'b0, 0);
      for (int i = 0; i < obs_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL illegal_trace cycle %0d: got step=%0d word=%h, expected step=%0d word=%h",
                     i, obs_q[i].stp, obs_q[i].word, exp_q[i].stp, exp_q[i].word);
         end
      end
      checks++;
      if ({illegal, Run, step} !== {exp_illegal, 1'b1, 4'd0}) begin
         errors++;
         $display("FAIL illegal_set: illegal=%b run=%b step=%0d, expected illegal=1 run=1 step=0",
                  illegal, Run, step);
      end
      run_instr(OP_ADD, 1'b0, 0, 1'b0, 0);
      checks++;
      if (illegal !== 1'b1) begin
         errors++;
         $display("FAIL illegal_sticky: got %b, expected 1", illegal);
      end
      clear = 1'b0;
      exp_illegal = 1'b0;
      #1;
      checks++;
      if (illegal !== exp_illegal) begin
         errors++;
         $display("FAIL illegal_clear: got %b, expected 0", illegal);
      end
      #1 clear = 1'b1;
      @(posedge Clock);
      #1;
   endtask

   task automatic test_clear_async();
      mem_ready = 1'b0;
      @(posedge Clock);
      #1;
      checks++;
      if ({step, Read} !== {4'd1, 1'b1}) begin
         errors++;
         $display("FAIL clear_pre: step=%0d Read=%b, expected step=1 Read=1", step, Read);
      end
      #2 clear = 1'b0;
      #1;
      checks++;
      if ({Run, step, dut_word(), illegal} !== 28'd0) begin
         errors++;
         $display("FAIL clear_async: run=%b step=%0d word=%h illegal=%b, expected all zero",
                  Run, step, dut_word(), illegal);
      end
      @(posedge Clock);
      #1 clear = 1'b1;
      @(posedge Clock);
      #1;
      checks++;
      if ({Run, step, dut_word()} !== {1'b1, 4'd0, W_T0}) begin
         errors++;
         $display("FAIL clear_restart: run=%b step=%0d word=%h, expected run=1 step=0 word=%h",
                  Run, step, dut_word(), W_T0);
      end
   endtask

   task automatic test_stop_halt();
      for (int pass = 0; pass < 2; pass++) begin
         exp_q.delete(); obs_q.delete();
         if (pass == 0) run_instr(OP_ADD, 1'b0, 0, 1'b1, 4);
         else           run_instr(OP_HALT, 1'b0, 1, 1'b0, 0);
         for (int i = 0; i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
               errors++;
               $display("FAIL stop_halt pass %0d cycle %0d: got step=%0d word=%h, expected step=%0d word=%h",
                        pass, i, obs_q[i].stp, obs_q[i].word, exp_q[i].stp, exp_q[i].word);
            end
         end
         repeat (4) begin
            mem_ready = 1'($urandom); Stop = 1'($urandom); IR = $urandom;
            #1;
            checks++;
            if ({Run, step, dut_word()} !== {1'b0, 4'd8, 22'd0}) begin
               errors++;
               $display("FAIL halt_hold pass %0d: run=%b step=%0d word=%h, expected run=0 step=8 word=0",
                        pass, Run, step, dut_word());
            end
            @(posedge Clock);
            #1;
         end
         Stop = 1'b0; mem_ready = 1'b0;
         clear = 1'b0;
         exp_illegal = 1'b0;
         #2 clear = 1'b1;
         @(posedge Clock);
         #1;
         checks++;
         if ({Run, step, dut_word()} !== {1'b1, 4'd0, W_T0}) begin
            errors++;
            $display("FAIL halt_restart pass %0d: run=%b step=%0d word=%h, expected run=1 step=0 word=%h",
                     pass, Run, step, dut_word(), W_T0);
         end
      end
   endtask

   task automatic test_random();
      logic [4:0] op;
      exp_q.delete(); obs_q.delete();
      repeat (30) begin
         op = 5'($urandom_range(0, 31));
         if (op == OP_HALT) op = OP_NOP;
         run_instr(op, 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'b0, 0);
      end
      for (int i = 0; i < obs_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL random cycle %0d: got run=%b step=%0d word=%h, expected run=%b step=%0d word=%h",
                     i, obs_q[i].run, obs_q[i].stp, obs_q[i].word, exp_q[i].run, exp_q[i].stp, exp_q[i].word);
         end
      end
      checks++;
      if (illegal !== exp_illegal) begin
         errors++;
         $display("FAIL random_illegal: got %b, expected %b", illegal, exp_illegal);
      end
   endtask

   initial begin
      test_reset();
      test_alu();
      test_mem_wait();
      test_branch();
      test_illegal();
      test_clear_async();
      test_stop_halt();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/minisrc_control_sequencer.md
# minisrc_control_sequencer

Hard-wired control unit for the Mini SRC processor. It sits directly upstream of the datapath and drives every register-enable, bus-select, ALU-select and memory strobe the datapath consumes. It steps through fetch (T0–T2) and per-opcode execute steps (T3–T7) from the opcode latched in IR, and it handshakes with memory on every read and write.

## Interface
- No parameters.
- Clock  in  1  system clock; all state updates on its rising edge.
- clear  in  1  asynchronous, active-low reset.
- IR  in  32  instruction register contents from the datapath; opcode is IR[31:27].
- CON  in  1  branch-condition flag from the datapath CON FF.
- Stop  in  1  external halt request.
- mem_ready  in  1  memory access complete.
- PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin, Zlowout  out  1 each  datapath strobes.
- Gra, Grb, Grc, Rin, Rout, BAout, Cout, CONin  out  1 each  register-select and bus strobes.
- Read, Write  out  1 each  memory strobes.
- alu_op  out  2  ALU operation: 0 ADD, 1 SUB, 2 AND, 3 OR.
- Run  out  1  high while executing.
- illegal  out  1  sticky unknown-opcode flag.
- step  out  4  current step for debug: 0–7 = T0–T7, 8 = HALT.

## Operation
- Opcodes: ld 00000, st 00010, add 00011, sub 00100, and 00101, or 00110, addi 01100, andi 01101, ori 01110, br 10010, nop 11010, halt 11011. Any other opcode executes as nop and sets `illegal`.
- Outputs are a combinational decode of the registered step and IR[31:27]. Any strobe not listed for a step is 0.
- T0: PCout, MARin, IncPC, Zin.
- T1: Zlowout, PCin, Read, MDRin.
- T2: MDRout, IRin.
- add/sub/and/or:
  - T3: Grb, Rout, Yin.
  - T4: Grc, Rout, alu_op from opcode, Zin.
  - T5: Zlowout, Gra, Rin, then T0.
- addi/andi/ori: as the register forms, except T4 uses Cout instead of Grc/Rout. ADD, AND and OR select alu_op 0, 2 and 3 respectively.
- ld:
  - T3: Grb, BAout, Yin.
  - T4: Cout, alu_op=0, Zin.
  - T5: Zlowout, MARin.
  - T6: Read, MDRin.
  - T7: MDRout, Gra, Rin, then T0.
- st:
  - T3–T5: as ld.
  - T6: Gra, Rout, MDRin.
  - T7: Write, then T0.
- br:
  - T3: Gra, Rout, CONin.
  - T4: PCout, Yin.
  - T5: Cout, alu_op=0, Zin.
  - T6: Zlowout, and PCin only if CON=1; then T0.
- nop: T3 with all strobes 0, then T0.
- halt: T3, then HALT.
- HALT: all strobes 0 and Run=0. Only `clear` leaves HALT.
- Stop is sampled only on the final step of an instruction. If Stop=1 there, the next state is HALT instead of T0. The in-flight instruction always completes.

## Timing
- While clear=0: step=T0 held, all strobes 0, alu_op=0, Run=0, illegal=0.
- First rising edge after clear deasserts: Run=1, and T0 strobes are active in that cycle.
- Read steps (T1; T6 of ld) and the Write step (T7 of st) hold their strobes and do not advance until mem_ready=1 is sampled. The step advances on the edge where mem_ready=1.
- mem_ready outside a Read/Write step is ignored.
- Zero-wait cycle counts including fetch:
  - ALU and immediate forms: 6.
  - ld, st: 8.
  - br: 7.
  - nop: 4.
- If clear asserts mid-instruction, all outputs are forced to reset values immediately (asynchronously). Memory strobes drop in the same cycle.
- IR may change only at T2 (IRin). The decode uses IR as presented in each cycle.

## Configuration
- SEQ_MEM_WAIT_EN defined: wait-state behaviour as above.
- SEQ_MEM_WAIT_EN undefined: memory is single-cycle. mem_ready is ignored, and Read/Write steps always advance after one cycle.

## Test plan
- Reset then add (IR=0x18000000 | regs), mem_ready tied 1: steps 0,1,2,3,4,5,0. Grc+Rout+alu_op=0 at T4. Gra+Rin at T5.
- sub, and, ori in sequence: alu_op=1 at T4 for sub, alu_op=2 for and; Cout=1 with alu_op=3 for ori.
- ld with mem_ready low for 3 cycles at T6: Read=MDRin=1 for 4 cycles, step stays 6, then T7 shows MDRout+Gra+Rin.
- br with CON=0, then br with CON=1: PCin=0 at T6 in the first case; Zlowout+PCin=1 at T6 in the second.
- Stop pulsed at T4 of add: add completes T5, then step=8, Run=0. Further clocks hold HALT. Pulsing clear restarts at T0.
- Opcode 11111: T3 idle, illegal=1 and sticky. Separately, clear asserted during T1 Read forces Read=0 without waiting for a clock edge.
